// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   state_e       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/sum width
//   cnt_w()       : width of the bit counter for a given operand width
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit counter width; never below 1 so the counter always exists
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand and result handshake bundle for serial_adder_ctrl.
//   in_valid/in_ready, a, b, cin : operand handshake
//   out_valid/out_ready, sum, cout : result handshake
//   busy : adder is shifting operand bits
// Modports: master = producer/consumer side, slave = adder side.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_fa_cell.sv
// Single-bit combinational full adder.
//   a_i, b_i, c_i : addend bits and carry-in
//   sum_c, carry_c : sum bit and carry-out
module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_c,
    output logic carry_c
);
    assign sum_c   = a_i ^ b_i ^ c_i;
    assign carry_c = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell driven LSB-first for WIDTH cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result handshakes (serial_adder_ctrl_if.slave)
//   ovf        : signed overflow flag, only with SERIAL_ADDER_OVERFLOW_EN
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic               ovf
`endif
);
    localparam int unsigned CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             fa_s, fa_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    serial_fa_cell u_fa (
        .a_i     (a_sh_q[0]),
        .b_i     (b_sh_q[0]),
        .c_i     (carry_q),
        .sum_c   (fa_s),
        .carry_c (fa_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        count_d  = count_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_c;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    // carry_q here is the carry into the MSB
                    ovf_d   = carry_q ^ fa_c;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status flags are registered copies of the next state
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_RUN);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            sum_q       <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign ovf           = ovf_q;
`endif

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder that sits directly around the single-bit full-adder stage and drives it one operand bit per clock.
- Accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake.
- Feeds LSB-first bits and a registered carry through the full-adder cell, collecting the sum bits into a shift register.
- Presents sum and carry-out through a second valid/ready handshake, trading WIDTH cycles of latency for a single adder cell.

Parameters:
WIDTH, 4, operand and sum width in bits (valid for WIDTH >= 2).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands; equals 1 only in IDLE.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum and cout are valid; equals 1 only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered sum.
cout  output  1  registered carry-out.
busy  output  1  high in RUN.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, sum=0, cout=0, count=0, internal shift registers=0, carry_q=0.
  - Consequently out_valid=0, busy=0, in_ready=1.
  - Handshakes are ignored while rst_n=0.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - On in_valid & in_ready: capture a_sh<=a, b_sh<=b, carry_q<=cin, count<=0, go to RUN.
  - Otherwise hold.
- RUN, every cycle:
  - Compute (s, c) = full_add(a_sh[0], b_sh[0], carry_q).
  - Shift: sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry_q <= c; count <= count+1.
  - When count == WIDTH-1: load sum <= {s, sum_sh[WIDTH-1:1]}, cout <= c, go to DONE.
- DONE:
  - out_valid=1; sum and cout stay stable until the transfer.
  - On out_ready: go to IDLE. sum and cout keep their last value; they are not cleared.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum.
  - in_ready=0 during RUN and DONE, so there is no overlap of a result transfer with a new accept.
  - in_valid held during RUN/DONE is not consumed.
- Arithmetic: unsigned. {cout, sum} = a + b + cin, modulo 2^(WIDTH+1) never exceeded.
- count width: $clog2(WIDTH). It cannot wrap because the RUN exit occurs at WIDTH-1.
- Reset mid-operation: any state returns immediately to IDLE and the partial result is discarded.
- out_ready is a don't-care outside DONE.

Optional Feature:
Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside cout, reset 0.
  - ovf = (carry into MSB) XOR (carry out of MSB), i.e. two's-complement signed overflow.
  - The MSB carry-in is latched as carry_q at count == WIDTH-1, before the final update.
- Not defined: no ovf port and no extra flops; behaviour is otherwise identical.

Decomposition:
- Package serial_adder_pkg:
  - state typedef (IDLE, RUN, DONE).
  - Default WIDTH constant.
  - Counter-width function/constant.
- Sub-module serial_fa_cell: purely combinational (a, b, c) -> (sum, carry), instantiated once in the RUN datapath.

Test Plan:
1. a=4'h3, b=4'h5, cin=0, accept at edge T -> out_valid rises at edge T+4; sum=4'h8, cout=0; busy high for exactly 4 cycles.
2. a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1. Then a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1.
3. Exhaustive sweep of all 512 (a, b, cin) combinations with out_ready=1 -> {cout, sum} == a+b+cin every time; in_ready returns high 1 cycle after each transfer.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> out_valid, sum, cout stable; in_ready=0; new operands not captured until after the transfer.
5. Reset: assert rst_n=0 two cycles into RUN of a=4'h9, b=4'h9 -> out_valid=0, busy=0, sum=0, cout=0, in_ready=1 immediately. After release, a=4'h7, b=4'h1 -> sum=4'h8, cout=0.
6. With SERIAL_ADDER_OVERFLOW_EN:
   - a=4'h7, b=4'h1 -> ovf=1.
   - a=4'h8, b=4'h8 -> sum=4'h0, cout=1, ovf=1.
   - a=4'h3, b=4'h2 -> ovf=0.
